pc_select_unit: RTL and testbench
=================================

// Module: pc_select_unit
// PURPOSE
//  Parametrised next-PC generator and PC register for the fetch stage. Selects among sequential, jump, JR and
//  branch targets by 2-bit mode, honours fetch stall, buffers a redirect that arrives while stalled, and
//  pulses IF flush. Sits between the EX/ID redirect logic and instruction memory.
// PARAMETERS
//  ADDR_W       32        PC/target width in bits
//  INSTR_BYTES  4         instruction size; power of 2; PC increment and alignment unit
//  RESET_PC     32'h0     PC value loaded on reset
//  EXC_VEC      32'h80    exception vector (used only with PCSEL_EXC_EN)
// PORTS
//  Clk            in   1       clock, rising edge
//  Reset_n        in   1       asynchronous, active-low reset
//  Stall          in   1       hold PC (hazard/imem not ready)
//  J_JR_Branch    in   2       00 seq, 01 jump (ID), 10 jr (ID), 11 branch (EX)
//  Redirect_Req   in   1       mode target valid this cycle (ignored when mode=00)
//  Jump_Target    in   ADDR_W  jump target from ID
//  JR_Target      in   ADDR_W  register target from ID
//  Branch_Target  in   ADDR_W  resolved taken-branch target from EX
//  Exc            in   1       exception request (PCSEL_EXC_EN only)
//  PC             out  ADDR_W  current fetch PC
//  PC_Plus        out  ADDR_W  PC + INSTR_BYTES, combinational from PC
//  Flush_IF       out  1       1-cycle pulse: PC loaded a redirect target
//  Pending        out  1       a buffered redirect is waiting for stall release
//  Misalign       out  1       1-cycle pulse: applied target had non-zero low bits (masked off)
// BEHAVIOUR
//  Reset (async, Reset_n=0): PC=RESET_PC, Flush_IF=0, Pending=0, Misalign=0, pend reg=0, state=RUN.
//  Priority of same-cycle requests: Exc > branch(11) > jr(10) > jump(01) > sequential.
//  States: RUN, STALL, PEND.
//   RUN:   Stall=0: redirect -> PC<=target, Flush_IF=1 next cycle; else PC<=PC_Plus.
//          Stall=1: no redirect -> STALL; redirect -> capture target+mode, ->PEND, PC holds.
//   STALL: PC holds; redirect -> capture, ->PEND; Stall=0 -> same as RUN with Stall=0, ->RUN.
//   PEND:  PC holds while Stall=1; new branch overwrites pend; new jr/jump overwrites only if pend not branch.
//          Stall=0: PC<=pend target (or higher-priority live request), Flush_IF=1, Pending=0, ->RUN.
//  Latency: redirect visible on PC one cycle after the accepting edge; never lost across any stall length.
//  Alignment: low log2(INSTR_BYTES) bits of applied target forced 0; Misalign pulses same cycle as Flush_IF.
//  Arithmetic: PC_Plus wraps modulo 2^ADDR_W (max aligned address -> 0), no flag.
//  Pending = (state==PEND). Mode 00 with Redirect_Req=1 treated as sequential.
//  Reset mid-PEND discards the buffered target.
// CONFIGURATION
//  PCSEL_EXC_EN defined: Exc port present; Exc=1 loads EXC_VEC next edge regardless of Stall, clears pend,
//   ->RUN, Flush_IF=1. Undefined: no Exc port, no vector logic; behaviour otherwise identical.
// STRUCTURE
//  Package pc_sel_pkg: mode encodings (PCS_SEQ/JUMP/JR/BRANCH), state enum, priority function.
//  Sub-module pc_redirect_arb: combinational priority pick of live request vs pend reg -> target, mode, valid.
//  Top: state FSM, PC register, pend registers, align mask, flush/misalign pulses.
// TESTING
//  Reset RESET_PC=0x0, 4 free cycles -> PC 0x0,0x4,0x8,0xC; Flush_IF=0 throughout.
//  PC=0x10, branch 0x40 with Stall=0 -> next PC=0x40, Flush_IF=1 for exactly 1 cycle.
//  Stall=1 at PC=0x20, jump 0x100 then branch 0x200 two cycles later, release after 5 cycles
//   -> PC holds 0x20, Pending=1, then PC=0x200, Flush_IF=1.
//  Same cycle jump 0x100 and (mode=11) branch 0x300 arbitration, plus jr target 0x103 -> PC=0x100, Misalign=1.
//  PC=0xFFFF_FFFC sequential -> PC=0x0; Reset_n low during PEND -> PC=RESET_PC, Pending=0.
//  PCSEL_EXC_EN: Exc=1 while Stall=1 and pend=0x200 -> PC=EXC_VEC, Pending=0, Flush_IF=1.

Source files
------------

// File: rtl/pc_sel_pkg.sv
// Shared encodings for the fetch-stage next-PC selector: redirect modes, FSM states
// and the rule for letting a newer redirect replace a buffered one.
package pc_sel_pkg;

    typedef enum logic [1:0] {
        PCS_SEQ    = 2'b00,
        PCS_JUMP   = 2'b01,
        PCS_JR     = 2'b10,
        PCS_BRANCH = 2'b11
    } pcs_mode_e;

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_STALL = 2'b01,
        ST_PEND  = 2'b10
    } pcs_state_e;

    // A resolved branch from EX is never displaced by a younger ID-stage jump/jr.
    function automatic logic pcs_overrides(input pcs_mode_e new_mode, input pcs_mode_e old_mode);
        return (new_mode == PCS_BRANCH) || (old_mode != PCS_BRANCH);
    endfunction

endpackage

// File: rtl/pc_redirect_arb.sv
// Combinational pick between the live redirect request and the buffered (pending)
// redirect; yields the winning target, its mode and a valid flag.
module pc_redirect_arb
    import pc_sel_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic [1:0]        mode,
    input  logic              req,
    input  logic [ADDR_W-1:0] jump_target,
    input  logic [ADDR_W-1:0] jr_target,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              pend_valid,
    input  pcs_mode_e         pend_mode,
    input  logic [ADDR_W-1:0] pend_target,
    output logic              sel_valid,
    output pcs_mode_e         sel_mode,
    output logic [ADDR_W-1:0] sel_target
);

    pcs_mode_e         live_mode;
    logic              live_valid;
    logic [ADDR_W-1:0] live_target;

    always_comb begin
        live_mode   = pcs_mode_e'(mode);
        live_valid  = req && (live_mode != PCS_SEQ);
        live_target = '0;
        case (live_mode)
            PCS_JUMP:   live_target = jump_target;
            PCS_JR:     live_target = jr_target;
            PCS_BRANCH: live_target = branch_target;
            default:    live_target = '0;
        endcase
    end

    always_comb begin
        sel_valid  = 1'b0;
        sel_mode   = PCS_SEQ;
        sel_target = '0;
        if (live_valid && (!pend_valid || pcs_overrides(live_mode, pend_mode))) begin
            sel_valid  = 1'b1;
            sel_mode   = live_mode;
            sel_target = live_target;
        end else if (pend_valid) begin
            sel_valid  = 1'b1;
            sel_mode   = pend_mode;
            sel_target = pend_target;
        end
    end

endmodule

// File: rtl/pc_select_unit.sv
// Fetch-stage PC register and next-PC selection with stall-safe redirect buffering.
// Optional exception vectoring is built when PCSEL_EXC_EN is defined.
//
// state | meaning
// RUN   | fetching normally, nothing buffered
// STALL | fetch held, no redirect buffered
// PEND  | fetch held, a redirect target is buffered until stall releases
module pc_select_unit
    import pc_sel_pkg::*;
#(
    parameter int unsigned       ADDR_W      = 32,
    parameter int unsigned       INSTR_BYTES = 4,
    parameter logic [ADDR_W-1:0] RESET_PC    = '0
`ifdef PCSEL_EXC_EN
    , parameter logic [ADDR_W-1:0] EXC_VEC   = ADDR_W'(32'h80)
`endif
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              Stall,
    input  logic [1:0]        J_JR_Branch,
    input  logic              Redirect_Req,
    input  logic [ADDR_W-1:0] Jump_Target,
    input  logic [ADDR_W-1:0] JR_Target,
    input  logic [ADDR_W-1:0] Branch_Target,
`ifdef PCSEL_EXC_EN
    input  logic              Exc,
`endif
    output logic [ADDR_W-1:0] PC,
    output logic [ADDR_W-1:0] PC_Plus,
    output logic              Flush_IF,
    output logic              Pending,
    output logic              Misalign
);

    localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'(INSTR_BYTES - 1);
    localparam logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(INSTR_BYTES);

    pcs_state_e        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    pcs_mode_e         pend_mode_q, pend_mode_d;
    logic [ADDR_W-1:0] pend_target_q, pend_target_d;
    logic              flush_q, flush_d;
    logic              misalign_q, misalign_d;

    logic              sel_valid;
    pcs_mode_e         sel_mode;
    logic [ADDR_W-1:0] sel_target;
    logic              load_tgt;
    logic [ADDR_W-1:0] tgt;

    pc_redirect_arb #(
        .ADDR_W (ADDR_W)
    ) u_arb (
        .mode          (J_JR_Branch),
        .req           (Redirect_Req),
        .jump_target   (Jump_Target),
        .jr_target     (JR_Target),
        .branch_target (Branch_Target),
        .pend_valid    (state_q == ST_PEND),
        .pend_mode     (pend_mode_q),
        .pend_target   (pend_target_q),
        .sel_valid     (sel_valid),
        .sel_mode      (sel_mode),
        .sel_target    (sel_target)
    );

    assign PC_Plus = pc_q + PC_STEP;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        pend_mode_d   = pend_mode_q;
        pend_target_d = pend_target_q;
        flush_d       = 1'b0;
        misalign_d    = 1'b0;
        load_tgt      = 1'b0;
        tgt           = sel_target;

        case (state_q)
            ST_PEND: begin
                if (Stall) begin
                    // arbiter already resolved whether the live request displaces the buffer
                    pend_mode_d   = sel_mode;
                    pend_target_d = sel_target;
                end else begin
                    load_tgt = 1'b1;
                    state_d  = ST_RUN;
                end
            end
            default: begin
                if (Stall) begin
                    if (sel_valid) begin
                        pend_mode_d   = sel_mode;
                        pend_target_d = sel_target;
                        state_d       = ST_PEND;
                    end else begin
                        state_d = ST_STALL;
                    end
                end else begin
                    if (sel_valid) begin
                        load_tgt = 1'b1;
                    end else begin
                        pc_d = PC_Plus;
                    end
                    state_d = ST_RUN;
                end
            end
        endcase

`ifdef PCSEL_EXC_EN
        if (Exc) begin
            load_tgt = 1'b1;
            tgt      = EXC_VEC;
            state_d  = ST_RUN;
        end
`endif

        if (load_tgt) begin
            pc_d          = tgt & ~LOW_MASK;
            flush_d       = 1'b1;
            misalign_d    = |(tgt & LOW_MASK);
            pend_mode_d   = PCS_SEQ;
            pend_target_d = '0;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q       <= ST_RUN;
            pc_q          <= RESET_PC;
            pend_mode_q   <= PCS_SEQ;
            pend_target_q <= '0;
            flush_q       <= 1'b0;
            misalign_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            pend_mode_q   <= pend_mode_d;
            pend_target_q <= pend_target_d;
            flush_q       <= flush_d;
            misalign_q    <= misalign_d;
        end
    end

    assign PC       = pc_q;
    assign Flush_IF = flush_q;
    assign Pending  = (state_q == ST_PEND);
    assign Misalign = misalign_q;

endmodule

// File: tb/tb_pc_select_unit.sv
// Self-checking bench for pc_select_unit: vector table through a scoreboard queue,
// plus hand sequences for reset-during-pend and (with PCSEL_EXC_EN) exceptions.
module tb_pc_select_unit;

    logic        Clk;
    logic        Reset_n;
    logic        Stall;
    logic [1:0]  J_JR_Branch;
    logic        Redirect_Req;
    logic [31:0] Jump_Target;
    logic [31:0] JR_Target;
    logic [31:0] Branch_Target;
    logic        exc;
    logic [31:0] PC;
    logic [31:0] PC_Plus;
    logic        Flush_IF;
    logic        Pending;
    logic        Misalign;

    int checks   = 0;
    int failures = 0;

    localparam logic [31:0] D = 32'hDEAD_BEE0;

    typedef struct {
        logic        stall;
        logic [1:0]  mode;
        logic        req;
        logic        exc;
        logic [31:0] jt;
        logic [31:0] jrt;
        logic [31:0] bt;
        logic [31:0] e_pc;
        logic        e_flush;
        logic        e_pend;
        logic        e_mis;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic        flush;
        logic        pend;
        logic        mis;
    } exp_t;

    vec_t vecs[$];
    exp_t sb_q[$];

    pc_select_unit dut (
        .Clk           (Clk),
        .Reset_n       (Reset_n),
        .Stall         (Stall),
        .J_JR_Branch   (J_JR_Branch),
        .Redirect_Req  (Redirect_Req),
        .Jump_Target   (Jump_Target),
        .JR_Target     (JR_Target),
        .Branch_Target (Branch_Target),
`ifdef PCSEL_EXC_EN
        .Exc           (exc),
`endif
        .PC            (PC),
        .PC_Plus       (PC_Plus),
        .Flush_IF      (Flush_IF),
        .Pending       (Pending),
        .Misalign      (Misalign)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    function automatic vec_t mk(input logic stall, input logic [1:0] mode, input logic req,
                                input logic [31:0] jt, input logic [31:0] jrt, input logic [31:0] bt,
                                input logic [31:0] e_pc, input logic e_flush, input logic e_pend,
                                input logic e_mis);
        vec_t v;
        v.stall = stall; v.mode = mode; v.req = req; v.exc = 1'b0;
        v.jt = jt; v.jrt = jrt; v.bt = bt;
        v.e_pc = e_pc; v.e_flush = e_flush; v.e_pend = e_pend; v.e_mis = e_mis;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        exp_t e;
        Stall        = v.stall;
        J_JR_Branch  = v.mode;
        Redirect_Req = v.req;
        exc          = v.exc;
        Jump_Target  = v.jt;
        JR_Target    = v.jrt;
        Branch_Target = v.bt;
        sb_q.push_back('{pc: v.e_pc, flush: v.e_flush, pend: v.e_pend, mis: v.e_mis});
        @(posedge Clk);
        #1;
        if (sb_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            chk({tag, "_pc"}, PC, e.pc);
            chk({tag, "_pc_plus"}, PC_Plus, e.pc + 32'd4);
            chk({tag, "_flush"}, {31'd0, Flush_IF}, {31'd0, e.flush});
            chk({tag, "_pending"}, {31'd0, Pending}, {31'd0, e.pend});
            chk({tag, "_misalign"}, {31'd0, Misalign}, {31'd0, e.mis});
        end
        @(negedge Clk);
    endtask

    initial begin
        vec_t v;
        Reset_n = 1'b1; Stall = 1'b0; J_JR_Branch = 2'b00; Redirect_Req = 1'b0; exc = 1'b0;
        Jump_Target = '0; JR_Target = '0; Branch_Target = '0;

        // stall, mode, req, jt, jrt, bt, expected pc, flush, pending, misalign
        vecs.push_back(mk(0, 2'b00, 0, D, D, D, 32'h004, 0, 0, 0));
        vecs.push_back(mk(0, 2'b00, 0, D, D, D, 32'h008, 0, 0, 0));
        vecs.push_back(mk(0, 2'b00, 0, D, D, D, 32'h00C, 0, 0, 0));
        vecs.push_back(mk(0, 2'b00, 0, D, D, D, 32'h010, 0, 0, 0));
        vecs.push_back(mk(0, 2'b11, 1, D, D, 32'h040, 32'h040, 1, 0, 0));
        vecs.push_back(mk(0, 2'b00, 0, D, D, D, 32'h044, 0, 0, 0));
        vecs.push_back(mk(0, 2'b01, 1, 32'h020, D, D, 32'h020, 1, 0, 0));
        vecs.push_back(mk(1, 2'b01, 1, 32'h100, D, D, 32'h020, 0, 1, 0));
        vecs.push_back(mk(1, 2'b00, 0, D, D, D, 32'h020, 0, 1, 0));
        vecs.push_back(mk(1, 2'b11, 1, D, D, 32'h200, 32'h020, 0, 1, 0));
        vecs.push_back(mk(1, 2'b01, 1, 32'h104, D, D, 32'h020, 0, 1, 0));
        vecs.push_back(mk(1, 2'b00, 0, D, D, D, 32'h020, 0, 1, 0));
        vecs.push_back(mk(0, 2'b00, 0, D, D, D, 32'h200, 1, 0, 0));
        vecs.push_back(mk(0, 2'b00, 0, D, D, D, 32'h204, 0, 0, 0));
        vecs.push_back(mk(0, 2'b01, 1, 32'h100, 32'h103, 32'h300, 32'h100, 1, 0, 0));
        vecs.push_back(mk(0, 2'b11, 1, 32'h100, 32'h103, 32'h300, 32'h300, 1, 0, 0));
        vecs.push_back(mk(0, 2'b10, 1, 32'h100, 32'h103, 32'h300, 32'h100, 1, 0, 1));
        vecs.push_back(mk(0, 2'b00, 0, D, D, D, 32'h104, 0, 0, 0));
        vecs.push_back(mk(0, 2'b00, 1, 32'h500, 32'h504, 32'h508, 32'h108, 0, 0, 0));
        vecs.push_back(mk(0, 2'b11, 0, D, D, 32'h600, 32'h10C, 0, 0, 0));
        vecs.push_back(mk(1, 2'b01, 1, 32'h500, D, D, 32'h10C, 0, 1, 0));
        vecs.push_back(mk(0, 2'b11, 1, D, D, 32'h600, 32'h600, 1, 0, 0));
        vecs.push_back(mk(1, 2'b11, 1, D, D, 32'h700, 32'h600, 0, 1, 0));
        vecs.push_back(mk(0, 2'b10, 1, D, 32'h800, D, 32'h700, 1, 0, 0));
        vecs.push_back(mk(1, 2'b10, 1, D, 32'h900, D, 32'h700, 0, 1, 0));
        vecs.push_back(mk(1, 2'b01, 1, 32'hA00, D, D, 32'h700, 0, 1, 0));
        vecs.push_back(mk(0, 2'b00, 0, D, D, D, 32'hA00, 1, 0, 0));
        vecs.push_back(mk(1, 2'b00, 0, D, D, D, 32'hA00, 0, 0, 0));
        vecs.push_back(mk(1, 2'b10, 1, D, 32'hB02, D, 32'hA00, 0, 1, 0));
        vecs.push_back(mk(0, 2'b00, 0, D, D, D, 32'hB00, 1, 0, 1));
        vecs.push_back(mk(1, 2'b00, 0, D, D, D, 32'hB00, 0, 0, 0));
        vecs.push_back(mk(0, 2'b01, 1, 32'hC00, D, D, 32'hC00, 1, 0, 0));
        vecs.push_back(mk(0, 2'b01, 1, 32'hFFFF_FFFC, D, D, 32'hFFFF_FFFC, 1, 0, 0));
        vecs.push_back(mk(0, 2'b00, 0, D, D, D, 32'h000, 0, 0, 0));
        vecs.push_back(mk(0, 2'b01, 1, 32'h050, D, D, 32'h050, 1, 0, 0));
        vecs.push_back(mk(1, 2'b01, 1, 32'h200, D, D, 32'h050, 0, 1, 0));

        #2 Reset_n = 1'b0;
        @(posedge Clk);
        #1;
        chk("reset_pc", PC, 32'h0);
        chk("reset_flush", {31'd0, Flush_IF}, 32'd0);
        chk("reset_pending", {31'd0, Pending}, 32'd0);
        chk("reset_misalign", {31'd0, Misalign}, 32'd0);
        @(negedge Clk);
        Reset_n = 1'b1;

        foreach (vecs[i]) run_vec(vecs[i], $sformatf("v%0d", i));

        // asynchronous reset while a redirect is buffered discards it
        #2 Reset_n = 1'b0;
        #1;
        chk("midpend_reset_pc", PC, 32'h0);
        chk("midpend_reset_pending", {31'd0, Pending}, 32'd0);
        chk("midpend_reset_flush", {31'd0, Flush_IF}, 32'd0);
        @(negedge Clk);
        Reset_n = 1'b1;
        run_vec(mk(0, 2'b00, 0, D, D, D, 32'h004, 0, 0, 0), "post_reset");

`ifdef PCSEL_EXC_EN
        run_vec(mk(1, 2'b11, 1, D, D, 32'h200, 32'h004, 0, 1, 0), "exc_setup");
        v = mk(1, 2'b00, 0, D, D, D, 32'h080, 1, 0, 0);
        v.exc = 1'b1;
        run_vec(v, "exc_take");
        run_vec(mk(0, 2'b00, 0, D, D, D, 32'h084, 0, 0, 0), "exc_after");
`else
        v = mk(0, 2'b00, 0, D, D, D, 32'h008, 0, 0, 0);
        run_vec(v, "seq_after");
`endif

        chk("sb_drained", sb_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
